moving_average_filter: RTL and testbench
========================================

# moving_average_filter

Parametrised successor to the fixed 8-bit moving averager: a streaming boxcar filter with configurable sample width, a compile-time maximum window of 2^LOG2_DEPTH samples, and a run-time window length selectable as any power of two up to that maximum. It sits between the sample-strobe input path and the output pins. Each accepted sample updates a running sum, and the block produces one averaged output per accepted sample, with a flag indicating when the window has filled.

## Interface
- DATA_W, default 8: sample and output width in bits, unsigned.
- LOG2_DEPTH, default 3: log2 of the maximum window length (8 samples by default).
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- clear  in  1  synchronous datapath clear; same effect as rst on the sum, taps, fill count and outputs.
- win_sel  in  $clog2(LOG2_DEPTH+1)  window exponent k; window = 2^k samples; values above LOG2_DEPTH clamp to LOG2_DEPTH.
- in_valid  in  1  sample strobe; every high cycle accepts one sample.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  one-cycle pulse; out_data is new.
- out_data  out  DATA_W  window average.
- out_full  out  1  window filled; at least 2^k samples accepted since the last clear or window change.

## Operation
- Delay line: 2^LOG2_DEPTH taps of DATA_W bits, all zero after reset or clear. On an accepted sample it shifts in in_data; tap[0] is the newest sample.
- Running sum: SUM_W = DATA_W + LOG2_DEPTH bits, unsigned. On accept: sum ← sum + in_data − tap[2^k − 1], where tap is taken before the shift. Empty slots hold zero, so the sum during warm-up is the plain total.
- Average: out_data = sum_next >> k, truncating. No overflow is possible, because the maximum sum is 2^k·(2^DATA_W − 1).
- Fill counter: saturates at 2^k. out_full = (count_next == 2^k).
- Window change: the block keeps a registered copy of the clamped win_sel. In any cycle where the clamped win_sel differs from the registered copy:
  - the registered copy updates;
  - taps, sum and count clear;
  - a sample accepted in that same cycle becomes the first sample of the new window.
- State is implicit: EMPTY (count = 0) → FILLING (0 < count < 2^k) → FULL (count = 2^k). Only rst, clear or a window change leave FULL.
- Precedence: rst > clear > window change > sample accept. When clear and in_valid are high together, the sample is dropped.
- Without in_valid: out_data, out_full, sum and taps all hold.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_full = 0, sum = 0, taps = 0, count = 0, registered window = clamped win_sel.
- Latency: in_valid high on cycle N → out_valid high on cycle N+1, with out_data covering samples up to and including the one from cycle N.
- Back-to-back samples are supported at 1 per cycle, with no stall and no backpressure.
- rst or clear asserted mid-stream: on the next edge all outputs read their reset values, and no out_valid is generated for a sample arriving in that cycle.

## Configuration
- MOVAVG_ROUND_EN defined: out_data = (sum_next + 2^(k−1)) >> k for k ≥ 1, i.e. round half up; k = 0 passes through unchanged. No overflow is possible; the maximum result is 2^DATA_W − 1.
- MOVAVG_ROUND_EN undefined: truncating shift only, and the rounding adder is not instantiated.

## Structure
- Package moving_average_pkg holds:
  - the SUM_W and window-select-width localparam functions;
  - a clamp function for win_sel;
  - a divide/round function shared by RTL and bench model.
- Sub-module mavg_delay_line, parametrised on DATA_W and depth, provides:
  - shift enable;
  - synchronous clear;
  - an indexed tap read port (tap[2^k − 1]).
- The top level holds the sum, fill counter, window register and output registers.

## Test plan
- Default parameters, k = 2, MOVAVG_ROUND_EN off, samples 1,2,3,4,0,1,2,3 each strobed one cycle with one idle cycle between:
  - out_data = 0,0,1,2,2,2,1,1;
  - out_full rises with the 4th output and stays high.
- Same stimulus with MOVAVG_ROUND_EN defined: out_data = 0,1,2,3,2,2,2,2.
- k = 3, eight back-to-back samples of 255: outputs 31,63,95,127,159,191,223,255 (truncating); sum = 2040 with no overflow; out_full on the 8th output.
- k = 2, full window streaming, then win_sel changed to 1 in the same cycle as sample 8:
  - next out_data = 4 (8 >> 1, i.e. 8/2 = 4, warm-up);
  - out_full low;
  - out_full high after one more sample.
- rst pulsed high for one cycle after three samples: all outputs 0 on the next edge; the following sample 6 with k = 1 gives out_data = 3.
- clear and in_valid high together: sample dropped, out_valid stays 0, sum reads 0 afterwards; in_valid held low for 10 cycles leaves out_data unchanged.

Source files
------------

// File: rtl/moving_average_pkg.sv
// ---------------------------------------------------------------------------
// moving_average_pkg
// Shared sizing helpers and arithmetic for the moving-average filter.
//   sum_width      : width of the running sum (DATA_W + LOG2_DEPTH)
//   win_sel_width  : width of the window-exponent select port
//   clamp_win      : limits a window exponent to LOG2_DEPTH
//   div_round      : divide by 2^k, optionally rounding half up
// ---------------------------------------------------------------------------
package moving_average_pkg;

    // Running-sum width: a full window of maximum samples never overflows it.
    function automatic int sum_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    // Window-select width; at least one bit even for a single-tap build.
    function automatic int win_sel_width(input int log2_depth);
        int w;
        w = $clog2(log2_depth + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Exponents above the compiled maximum select the largest window.
    function automatic logic [7:0] clamp_win(input logic [7:0] sel,
                                             input logic [7:0] log2_depth);
        logic [7:0] res;
        if (sel > log2_depth) begin
            res = log2_depth;
        end else begin
            res = sel;
        end
        return res;
    endfunction

    // sum / 2^k; with round_en the half-LSB bias gives round-half-up.
    // k = 0 has no fractional part, so no bias is added.
    function automatic logic [63:0] div_round(input logic [63:0] sum,
                                              input logic [7:0]  k,
                                              input logic        round_en);
        logic [63:0] bias;
        if (round_en && (k != 8'd0)) begin
            bias = 64'd1 << (k - 8'd1);
        end else begin
            bias = 64'd0;
        end
        return (sum + bias) >> k;
    endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// ---------------------------------------------------------------------------
// mavg_delay_line
// Sample delay line for the moving-average filter. tap[0] holds the newest
// sample. The read port is combinational and returns the tap contents
// before any shift on the coming edge.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, zeroes all taps
//   clr      in   synchronous clear, zeroes all taps
//   shift_en in   shift din into tap[0]
//   din      in   sample to shift in
//   rd_idx   in   tap index to read
//   rd_data  out  tap[rd_idx]
// clr together with shift_en restarts the line with din as the only
// non-zero sample (used when a new window starts on an accepted sample).
// ---------------------------------------------------------------------------
module mavg_delay_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] taps_r [DEPTH];

    // Tap storage: reset/clear, restart-with-sample, or plain shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 1; i < DEPTH; i++) begin
                taps_r[i] <= '0;
            end
            if (shift_en) begin
                taps_r[0] <= din;
            end else begin
                taps_r[0] <= '0;
            end
        end else if (shift_en) begin
            taps_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_r[i] <= taps_r[i-1];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_r[i] <= taps_r[i];
            end
        end
    end

    // Pre-shift tap read.
    always_comb begin
        rd_data = taps_r[rd_idx];
    end

endmodule

// File: rtl/moving_average_filter.sv
// ---------------------------------------------------------------------------
// moving_average_filter
// Streaming boxcar averager. Window = 2^k samples, k chosen at run time by
// win_sel (clamped to LOG2_DEPTH). One averaged output per accepted sample,
// one cycle after acceptance.
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   clear     in   synchronous datapath clear (drops a coincident sample)
//   win_sel   in   window exponent k
//   in_valid  in   sample strobe
//   in_data   in   sample value (unsigned)
//   out_valid out  one-cycle pulse, out_data is new
//   out_data  out  window average
//   out_full  out  at least 2^k samples since last clear/window change
// Optional build macro MOVAVG_ROUND_EN: round half up instead of truncating.
// ---------------------------------------------------------------------------
module moving_average_filter
    import moving_average_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [win_sel_width(LOG2_DEPTH)-1:0] win_sel,
    input  logic                                 in_valid,
    input  logic [DATA_W-1:0]                    in_data,
    output logic                                 out_valid,
    output logic [DATA_W-1:0]                    out_data,
    output logic                                 out_full
);

    localparam int SUM_W  = sum_width(DATA_W, LOG2_DEPTH);
    localparam int WSEL_W = win_sel_width(LOG2_DEPTH);
    localparam int CNT_W  = LOG2_DEPTH + 1;
    localparam int DEPTH  = 1 << LOG2_DEPTH;

    logic [WSEL_W-1:0]     win_r;
    logic [SUM_W-1:0]      sum_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  out_valid_r;
    logic [DATA_W-1:0]     out_data_r;
    logic                  out_full_r;

    logic [WSEL_W-1:0]     win_clamped_s;
    logic                  win_change_s;
    logic [WSEL_W-1:0]     win_eff_s;
    logic [CNT_W-1:0]      win_len_s;
    logic [LOG2_DEPTH-1:0] tap_idx_s;
    logic [DATA_W-1:0]     tap_s;
    logic [SUM_W-1:0]      sum_next_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [DATA_W-1:0]     avg_s;
    logic                  full_next_s;
    logic                  line_clr_s;
    logic                  line_shift_s;

    // Window selection: a change takes effect in the same cycle it is seen.
    always_comb begin
        win_clamped_s = WSEL_W'(clamp_win(8'(win_sel), 8'(LOG2_DEPTH)));
        win_change_s  = (win_clamped_s != win_r);
        if (win_change_s) begin
            win_eff_s = win_clamped_s;
        end else begin
            win_eff_s = win_r;
        end
        win_len_s = CNT_W'(1) << win_eff_s;
        tap_idx_s = LOG2_DEPTH'(win_len_s - CNT_W'(1));
    end

    // Delay-line controls. A clear drops the coincident sample; a window
    // change restarts the line with the coincident sample.
    always_comb begin
        line_clr_s   = clear | win_change_s;
        line_shift_s = in_valid & ~clear;
    end

    mavg_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (LOG2_DEPTH)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .clr      (line_clr_s),
        .shift_en (line_shift_s),
        .din      (in_data),
        .rd_idx   (tap_idx_s),
        .rd_data  (tap_s)
    );

    // Next sum / fill count for an accepted sample. The oldest tap is always
    // part of the current sum, so the subtraction never underflows.
    always_comb begin
        if (win_change_s) begin
            sum_next_s = SUM_W'(in_data);
            cnt_next_s = CNT_W'(1);
        end else begin
            sum_next_s = sum_r + SUM_W'(in_data) - SUM_W'(tap_s);
            if (cnt_r >= win_len_s) begin
                cnt_next_s = win_len_s;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end
        full_next_s = (cnt_next_s == win_len_s);
    end

    // Average of the updated sum.
    always_comb begin
`ifdef MOVAVG_ROUND_EN
        avg_s = DATA_W'(div_round(64'(sum_next_s), 8'(win_eff_s), 1'b1));
`else
        avg_s = DATA_W'(sum_next_s >> win_eff_s);
`endif
    end

    // Datapath state and output registers; rst > clear > window change > sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r       <= win_clamped_s;
            sum_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_full_r  <= 1'b0;
        end else if (clear) begin
            win_r       <= win_r;
            sum_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_full_r  <= 1'b0;
        end else if (in_valid) begin
            win_r       <= win_eff_s;
            sum_r       <= sum_next_s;
            cnt_r       <= cnt_next_s;
            out_valid_r <= 1'b1;
            out_data_r  <= avg_s;
            out_full_r  <= full_next_s;
        end else if (win_change_s) begin
            // New window with no sample yet: empty, average output holds.
            win_r       <= win_clamped_s;
            sum_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_full_r  <= 1'b0;
        end else begin
            win_r       <= win_r;
            sum_r       <= sum_r;
            cnt_r       <= cnt_r;
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_full_r  <= out_full_r;
        end
    end

    // Ports driven straight from registers.
    always_comb begin
        out_valid = out_valid_r;
        out_data  = out_data_r;
        out_full  = out_full_r;
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// ---------------------------------------------------------------------------
// tb_moving_average_filter
// Self-checking bench: directed scenarios plus random stimulus compared each
// cycle against a queue-based model of the boxcar average.
// ---------------------------------------------------------------------------
module tb_moving_average_filter;

    localparam int DATA_W     = 8;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 1 << LOG2_DEPTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [1:0]        win_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_full;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    int hist[$];
    int m_k;
    int m_cnt;
    int e_valid;
    int e_data;
    int e_full;

    moving_average_filter #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .win_sel   (win_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_full  (out_full)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int avg_of(input int s, input int k);
`ifdef MOVAVG_ROUND_EN
        if (k > 0) return (s + (1 << (k - 1))) / (1 << k);
        return s;
`else
        return s / (1 << k);
`endif
    endfunction

    // Reference behaviour: average of the last 2^k samples accepted since
    // the last reset, clear or window change.
    task automatic model_step(input int r, input int c, input int ws, input int v, input int d);
        int kc;
        int s;
        int n;
        kc = (ws > LOG2_DEPTH) ? LOG2_DEPTH : ws;
        if (r != 0) begin
            hist.delete(); m_cnt = 0; m_k = kc;
            e_valid = 0; e_data = 0; e_full = 0;
        end else if (c != 0) begin
            hist.delete(); m_cnt = 0;
            e_valid = 0; e_data = 0; e_full = 0;
        end else begin
            if (kc != m_k) begin
                m_k = kc; hist.delete(); m_cnt = 0; e_full = 0;
            end
            if (v != 0) begin
                hist.push_front(d);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                n = (hist.size() < (1 << m_k)) ? hist.size() : (1 << m_k);
                s = 0;
                for (int i = 0; i < n; i++) s += hist[i];
                m_cnt = (m_cnt + 1 > (1 << m_k)) ? (1 << m_k) : m_cnt + 1;
                e_data  = avg_of(s, m_k);
                e_full  = (m_cnt == (1 << m_k)) ? 1 : 0;
                e_valid = 1;
            end else begin
                e_valid = 0;
            end
        end
    endtask

    // One clock: drive at negedge, model the edge, check #1 after it.
    task automatic step(input int r, input int c, input int ws, input int v, input int d);
        rst      = (r != 0);
        clear    = (c != 0);
        win_sel  = 2'(ws);
        in_valid = (v != 0);
        in_data  = DATA_W'(d);
        @(posedge clk);
        model_step(r, c, ws, v, d);
        #1;
        check_val("out_valid", 32'(out_valid), 32'(e_valid));
        check_val("out_data",  32'(out_data),  32'(e_data));
        check_val("out_full",  32'(out_full),  32'(e_full));
        @(negedge clk);
    endtask

    int seq_a[8] = '{1, 2, 3, 4, 0, 1, 2, 3};
`ifdef MOVAVG_ROUND_EN
    int exp_a[8] = '{0, 1, 2, 3, 2, 2, 2, 2};
`else
    int exp_a[8] = '{0, 0, 1, 2, 2, 2, 1, 1};
`endif

    initial begin
        int r, c, ws, v, d;
        hist.delete();
        m_k = 0; m_cnt = 0; e_valid = 0; e_data = 0; e_full = 0;
        rst = 1'b1; clear = 1'b0; win_sel = 2'd2; in_valid = 1'b0; in_data = '0;
        @(negedge clk);

        // Reset state
        step(1, 0, 2, 0, 0);
        step(1, 0, 2, 0, 0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data",  32'(out_data),  32'd0);
        check_val("rst_full",  32'(out_full),  32'd0);

        // k = 2, samples with idle cycles between
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 2, 1, seq_a[i]);
            check_val("seqA_data", 32'(out_data), 32'(exp_a[i]));
            check_val("seqA_full", 32'(out_full), (i >= 3) ? 32'd1 : 32'd0);
            step(0, 0, 2, 0, 0);
        end

        // k = 3, eight back-to-back maximum samples
        step(0, 1, 3, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 3, 1, 255);
`ifndef MOVAVG_ROUND_EN
            check_val("max_data", 32'(out_data), 32'((255 * (i + 1)) >> 3));
`endif
            check_val("max_full", 32'(out_full), (i == 7) ? 32'd1 : 32'd0);
        end

        // k = 2 streaming, window change to k = 1 on sample 8
        step(0, 1, 2, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, 0, 2, 1, i);
        step(0, 0, 1, 1, 8);
        check_val("wchg_data", 32'(out_data), 32'd4);
        check_val("wchg_full", 32'(out_full), 32'd0);
        step(0, 0, 1, 1, 2);
        check_val("wchg_full2", 32'(out_full), 32'd1);
        check_val("wchg_data2", 32'(out_data), 32'd5);

        // rst pulse mid-stream
        step(0, 0, 1, 1, 5);
        step(0, 0, 1, 1, 5);
        step(0, 0, 1, 1, 5);
        step(1, 0, 1, 1, 7);
        check_val("rstm_valid", 32'(out_valid), 32'd0);
        check_val("rstm_data",  32'(out_data),  32'd0);
        step(0, 0, 1, 1, 6);
        check_val("rstm_after", 32'(out_data), 32'd3);

        // clear with in_valid: sample dropped, then hold over idle cycles
        step(0, 0, 1, 1, 9);
        step(0, 1, 1, 1, 7);
        check_val("clr_valid", 32'(out_valid), 32'd0);
        step(0, 0, 1, 1, 9);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
`ifdef MOVAVG_ROUND_EN
        check_val("clr_hold", 32'(out_data), 32'd5);
`else
        check_val("clr_hold", 32'(out_data), 32'd4);
`endif

        // Randomized stimulus
        ws = 2;
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 99) < 1) ? 1 : 0;
            c = ($urandom_range(0, 99) < 3) ? 1 : 0;
            if ($urandom_range(0, 99) < 8) ws = $urandom_range(0, 3);
            v = ($urandom_range(0, 99) < 70) ? 1 : 0;
            d = $urandom_range(0, 255);
            step(r, c, ws, v, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
